// File: rtl/ripple_carry_adder_reg.sv
// Ripple-carry adder with registered sum, carry-out and signed overflow.
// Baseline adder: an explicit chain of 1-bit full adders, no lookahead.

module rca_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term shared by the sum and carry equations
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

module ripple_carry_adder_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Cin,
    output logic [DATA_WIDTH-1:0] S,
    output logic                  CF,
    output logic                  OF
);

    logic [DATA_WIDTH-1:0] sum_c;
    logic                  carry_out;
    logic                  carry_msb_in;

    // One full adder per bit; each stage owns its own carry nets so the
    // chain is a plain sequence of distinct signals.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fa
        logic ci;
        logic co;

        if (i == 0) begin : g_first
            assign ci = Cin;
        end else begin : g_next
            assign ci = g_fa[i-1].co;
        end

        rca_full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (ci),
            .s  (sum_c[i]),
            .co (co)
        );
    end

    // Carry out of the MSB and carry into the MSB; for a 1-bit adder the
    // latter is Cin itself.
    assign carry_out    = g_fa[DATA_WIDTH-1].co;
    assign carry_msb_in = g_fa[DATA_WIDTH-1].ci;

    // Capture sum and flags every cycle; reset clears them immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S  <= '0;
            CF <= 1'b0;
            OF <= 1'b0;
        end else begin
            S  <= sum_c;
            CF <= carry_out;
            OF <= carry_out ^ carry_msb_in;
        end
    end

endmodule

// File: tb/tb_ripple_carry_adder_reg.sv
// Self-checking bench for ripple_carry_adder_reg (DATA_WIDTH = 8).
// Directed corner cases, reset behaviour and random operands vs. a reference model.

module tb_ripple_carry_adder_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cf;
    logic         of;

    int n_checks;
    int n_fail;

    ripple_carry_adder_reg #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .S     (s),
        .CF    (cf),
        .OF    (of)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer addition, overflow from operand/result signs
    task automatic model(input int av, input int bv, input int cv,
                         output int es, output int ecf, output int eof);
        int total;
        int sa;
        int sb;
        int sr;
        total = av + bv + cv;
        es    = total % 256;
        ecf   = (total >= 256) ? 1 : 0;
        sa    = (av >= 128) ? 1 : 0;
        sb    = (bv >= 128) ? 1 : 0;
        sr    = (es >= 128) ? 1 : 0;
        eof   = (sa == sb && sr != sa) ? 1 : 0;
    endtask

    // Drive one operand set, let one edge capture it, compare just after
    task automatic run_vec(input string tag, input int av, input int bv,
                           input int cv);
        int es;
        int ecf;
        int eof;
        model(av, bv, cv, es, ecf, eof);
        a   = W'(av);
        b   = W'(bv);
        cin = cv[0];
        @(posedge clk);
        #1;
        check({tag, ".S"},  32'(s),  32'(es));
        check({tag, ".CF"}, 32'(cf), 32'(ecf));
        check({tag, ".OF"}, 32'(of), 32'(eof));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".S"},  32'(s),  32'd0);
        check({tag, ".CF"}, 32'(cf), 32'd0);
        check({tag, ".OF"}, 32'(of), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        check_zero("rst_async");

        // Reset held across an edge with nonzero inputs
        a   = 8'hFF;
        b   = 8'hFF;
        cin = 1'b1;
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        rst_n = 1'b1;

        // Directed corners
        run_vec("pos_ovf",  8'h7F, 8'h01, 0);
        run_vec("uwrap",    8'hFF, 8'h01, 0);
        run_vec("neg_ovf",  8'h80, 8'h80, 0);
        run_vec("cin_wrap", 8'h0F, 8'hF0, 1);
        run_vec("max_cin",  8'hFF, 8'hFF, 1);
        run_vec("zero",     8'h00, 8'h00, 0);
        run_vec("cin_only", 8'h00, 8'h00, 1);
        run_vec("ovf_cin",  8'h7F, 8'h00, 1);

        // Stream interrupted by reset
        run_vec("str1", 8'h01, 8'h01, 0);
        run_vec("str2", 8'h02, 8'h01, 0);
        run_vec("str3", 8'h03, 8'h01, 0);
        a = 8'h04;
        #2 rst_n = 1'b0;
        #1;
        check_zero("str_rst_now");
        @(posedge clk);
        #1;
        check_zero("str_rst_hold");
        rst_n = 1'b1;
        run_vec("str4", 8'h04, 8'h01, 0);
        run_vec("str5", 8'h05, 8'h01, 0);

        // Random operands, one pair per cycle
        for (int i = 0; i < 3000; i++) begin
            run_vec("rand", int'($urandom_range(255)),
                    int'($urandom_range(255)), int'($urandom_range(1)));
        end

        // Full sweep of A with B at sign-boundary values
        for (int i = 0; i < 256; i++) begin
            run_vec("sweep7f", i, 8'h7F, i % 2);
            run_vec("sweep80", i, 8'h80, (i / 2) % 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
